// File: rtl/status_buffer_pkg.sv
// Shared constants, cell layout and FSM encoding for the double-buffered status store.
package status_buffer_pkg;

  localparam int unsigned CELLS      = 30;
  localparam int unsigned CELL_W     = 8;
  localparam int unsigned STATUS_W   = CELLS * CELL_W;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned FRAME_W    = 8;

  localparam int unsigned LETTER_LSB = 0;
  localparam int unsigned LETTER_W   = 5;
  localparam int unsigned COLOUR_LSB = 5;
  localparam int unsigned COLOUR_W   = 3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELLS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [COLOUR_W-1:0] colour;
    logic [LETTER_W-1:0] letter;
  } cell_t;

  // Addresses at or beyond CELLS are dropped rather than aliased.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(CELLS);
  endfunction

endpackage

// File: rtl/status_buffer.sv
// Shadow/front game-status store: writes land in shadow, commits publish to the front copy at vsync.
module status_buffer
  import status_buffer_pkg::*;
#(
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CELL_W-1:0]   wr_data,
  input  logic                commit,
  input  logic                clear,
  input  logic                vsync,
  output logic                wr_ready,
  output logic                pending,
  output logic [STATUS_W-1:0] status,
  output logic [FRAME_W-1:0]  frame_cnt
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                vsync_q;
  logic                vs_edge;
  logic                publish;
  logic [STATUS_W-1:0] shadow_q;

  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  cell_t               sel_cell;
  logic [CELLS-1:0]    cell_we;

  assign vs_edge = (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);

  // State register; wr_ready is registered from the next state so it tracks IDLE exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      wr_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ready <= (state_d == ST_IDLE);
    end
  end

  // Next-state logic: clear walks idx over every cell exactly once.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic: one shadow cell write per cycle plus the publish strobe.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_cell = '0;
    cell_we  = '0;
    publish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!clear && wr_en && addr_ok(wr_addr)) begin
          sel_we   = 1'b1;
          sel_addr = wr_addr;
          sel_cell = cell_t'(wr_data);
        end
        publish = vs_edge && pending;
      end
      ST_CLEAR: begin
        sel_we   = 1'b1;
        sel_addr = idx_q;
      end
      default: ;
    endcase
    for (int i = 0; i < int'(CELLS); i++) begin
      cell_we[i] = sel_we && (sel_addr == ADDR_W'(i));
    end
  end

  // Shadow copy, written through per-cell enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
    end else begin
      for (int i = 0; i < int'(CELLS); i++) begin
        if (cell_we[i]) shadow_q[i*CELL_W +: CELL_W] <= sel_cell;
      end
    end
  end

  // Front copy, commit tracking, vsync history and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status    <= '0;
      pending   <= 1'b0;
      vsync_q   <= !VSYNC_ACTIVE;
      frame_cnt <= '0;
    end else begin
      vsync_q <= vsync;
      if (vs_edge) frame_cnt <= frame_cnt + FRAME_W'(1);
      if (publish) begin
        status  <= shadow_q;
        pending <= commit;
      end else if (commit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
